alu_share_arbiter: RTL
======================

# alu_share_arbiter

Round-robin arbiter and sequencer that shares the single combinational ALU among `NUM_REQ` requesters, such as the integer pipeline and the address/branch unit. It accepts one operation at a time over a valid/ready request port and registers its operands onto the ALU inputs. It holds multiply for a configurable number of cycles, captures the ALU result, and returns it with the requester ID over a valid/ready response port.

## Interface
- `NUM_REQ`, default 2: number of requesters, ≥2.
- `DATA_W`, default 32: operand/result width; must match the ALU.
- `MUL_CYCLES`, default 1: EXEC cycles for op `4'b0110` (multiply), ≥1. All other ops take 1 cycle.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester accept; at most one bit set.
- `req_a` in `NUM_REQ*DATA_W`: flattened operand A; requester i at `[i*DATA_W +: DATA_W]`.
- `req_b` in `NUM_REQ*DATA_W`: flattened operand B, same packing.
- `req_op` in `NUM_REQ*4`: flattened ALU control code.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out `$clog2(NUM_REQ)`: index of the requester that owns the result.
- `rsp_result` out `DATA_W`: captured ALU result.
- `alu_inp1`, `alu_inp2` out `DATA_W`: to the ALU inputs; registered.
- `alu_control` out 4: to the ALU control input; registered.
- `alu_result` in `DATA_W`: from the ALU output.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - The round-robin grant selects the first valid requester at or after pointer `ptr`.
  - `req_ready` is set only for that requester.
  - On handshake (`req_valid[g] & req_ready[g]`):
    - latch A, B and op into `alu_inp1`/`alu_inp2`/`alu_control`;
    - latch `g` into `rsp_id`;
    - set `ptr <= (g+1) mod NUM_REQ`;
    - load `cnt` with `MUL_CYCLES-1` if op is `4'b0110`, else 0;
    - go to EXEC.
  - With no valid requester, stay in IDLE and leave `ptr` unchanged.
- **EXEC:**
  - ALU inputs are stable.
  - If `cnt != 0`, decrement it.
  - Otherwise, capture `alu_result` into `rsp_result`, set `rsp_valid`, and go to RESP.
- **RESP:**
  - Hold `rsp_valid`, `rsp_id` and `rsp_result` stable until `rsp_ready`.
  - On `rsp_ready`, clear `rsp_valid` and go to IDLE.
  - No new request is accepted in this cycle.
- **Op codes:** forwarded unchanged, including codes the ALU does not define (the ALU returns A for those). No decoding is done here except multiply detection.
- **ALU outputs:** keep their last latched values outside EXEC; they change only on a request handshake.
- **Requester rules:** a requester must hold valid, operands and op stable until ready. `req_ready` may depend on `req_valid`; requesters must not make valid depend on ready.
- **Reset:**
  - Async assertion at any time, including mid-EXEC or RESP, aborts the transaction with no response.
  - State → IDLE, `ptr` → 0, `cnt` → 0.
  - All outputs → 0: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_result`, `alu_inp1`, `alu_inp2`, `alu_control`, `busy`.

## Timing
- Handshake in cycle N; the ALU sees the operands from cycle N+1.
- `rsp_valid` rises at N+2 for non-multiply ops and at N+1+`MUL_CYCLES` for multiply.
- The earliest next handshake comes one cycle after the response handshake. Back-to-back throughput is one op per 3 cycles (non-multiply, `rsp_ready` held high).
- No combinational path from `alu_result` to any output. The `req_valid`→`req_ready` path is combinational (one arbiter level).
- Simultaneous requests are ordered strictly by `ptr`. A requester that stays valid waits at most `NUM_REQ-1` grants.

## Structure
- Shared package `alu_pkg`:
  - op-code constants (`ALU_AND`=0000, `ALU_OR`=0001, `ALU_ADD`=0010, `ALU_SUB`=0100, `ALU_SLT`=1000, `ALU_SLL`=0011, `ALU_SRL`=0101, `ALU_MUL`=0110, `ALU_XOR`=0111);
  - FSM state enum `arb_state_t`.
- One sub-module, `rr_arbiter`: combinational one-hot grant from `req_valid` and `ptr`, plus encoded index. Pointer update stays in the parent.

## Test plan
- **Reset values:** assert `rst_n`=0 with all inputs random → every output 0, `busy`=0; release, no requests → stays IDLE.
- **Single add:** requester 0 sends A=5, B=7, op `0010` at cycle N → `alu_inp1`=5 / `alu_inp2`=7 at N+1; `rsp_valid`=1, `rsp_result`=12, `rsp_id`=0 at N+2.
- **Round-robin:** both requesters valid continuously (req0 A=1,B=1 add; req1 A=9,B=4 sub), `rsp_ready`=1 → responses alternate id 0 (2), 1 (5), 0, 1; neither starves.
- **Multiply latency:** with `MUL_CYCLES`=3, req1 sends 6×7 op `0110` at N → `rsp_valid` at N+4, result 42; `busy` high N+1..N+4.
- **Back-pressure:** `rsp_ready`=0 for 5 cycles after `rsp_valid` → result and id held stable, all `req_ready`=0; `rsp_ready`=1 → `rsp_valid` drops next cycle, new grant possible the cycle after.
- **Reset mid-op:** pull `rst_n` low during EXEC of a multiply → immediate return to the reset values, no response; next request is granted starting from requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sharing logic: ALU control codes, the
// sequencer FSM state type and a multiply-detect helper.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_MUL = 4'b0110;
   localparam logic [3:0] ALU_XOR = 4'b0111;
   localparam logic [3:0] ALU_SLT = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

   // Multiply is the only op that needs more than one EXEC cycle.
   function automatic logic is_mul(input logic [3:0] op);
      return (op == ALU_MUL);
   endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant: picks the first asserted req_valid bit at
// or after index ptr, wrapping around. The pointer itself lives in the parent.
// Ports:
//   req_valid  in  NUM_REQ   per-requester valid
//   ptr        in  ID_W      highest-priority index this cycle (< NUM_REQ)
//   grant      out NUM_REQ   one-hot grant (all zero when nothing valid)
//   grant_idx  out ID_W      encoded index of the granted requester
//   grant_any  out 1         some requester is granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx,
   output logic                       grant_any
);

   localparam int ID_W = $clog2(NUM_REQ);

   int idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         // Walk ptr, ptr+1, ... modulo NUM_REQ; first hit wins.
         idx = int'(ptr) + off;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!grant_any && idx < NUM_REQ && req_valid[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = ID_W'(idx);
            grant_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU among NUM_REQ requesters. One operation at a
// time is accepted (round-robin), its operands are registered onto the ALU
// inputs, the result is captured after 1 cycle (MUL_CYCLES for multiply) and
// returned together with the requester index.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Producers hold valid and payload stable until ready; valid never
// depends on ready. req_ready may depend combinationally on req_valid.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   req_valid/req_ready    per-requester request handshake
//   req_a/req_b/req_op     flattened operands / op, requester i at [i*W +: W]
//   rsp_valid/rsp_ready    response handshake
//   rsp_id, rsp_result     owner index and captured ALU result
//   alu_inp1/2, alu_control registered ALU inputs
//   alu_result             ALU output
//   busy                   state is not IDLE
//   fsm_state              current FSM state (observation only)
// -----------------------------------------------------------------------------
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int DATA_W     = 32,
   parameter int MUL_CYCLES = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]    req_a,
   input  logic [NUM_REQ*DATA_W-1:0]    req_b,
   input  logic [NUM_REQ*4-1:0]         req_op,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
   output logic [DATA_W-1:0]            rsp_result,
   output logic [DATA_W-1:0]            alu_inp1,
   output logic [DATA_W-1:0]            alu_inp2,
   output logic [3:0]                   alu_control,
   input  logic [DATA_W-1:0]            alu_result,
   output logic                         busy,
   output logic [1:0]                   fsm_state
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   arb_state_t         state, state_next;
   logic [ID_W-1:0]    ptr;
   logic [CNT_W-1:0]   cnt;

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_idx;
   logic               grant_any;
   logic               accept;
   logic [3:0]         op_sel;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_valid (req_valid),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // rst_n gates ready so that no grant is visible while reset is held.
   assign req_ready = (state == ST_IDLE && rst_n) ? grant : '0;
   assign accept    = (state == ST_IDLE) && grant_any;
   assign op_sel    = req_op[grant_idx*4 +: 4];

   assign rsp_valid = (state == ST_RESP);
   assign busy      = (state != ST_IDLE);
   assign fsm_state = state;

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (accept)         state_next = ST_EXEC;
         ST_EXEC: if (cnt == '0)      state_next = ST_RESP;
         ST_RESP: if (rsp_ready)      state_next = ST_IDLE;
         default:                     state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         cnt         <= '0;
         rsp_id      <= '0;
         rsp_result  <= '0;
         alu_inp1    <= '0;
         alu_inp2    <= '0;
         alu_control <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            alu_inp1    <= req_a[grant_idx*DATA_W +: DATA_W];
            alu_inp2    <= req_b[grant_idx*DATA_W +: DATA_W];
            alu_control <= op_sel;
            rsp_id      <= grant_idx;
            ptr         <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
            cnt         <= is_mul(op_sel) ? CNT_W'(MUL_CYCLES-1) : '0;
         end
         if (state == ST_EXEC) begin
            // cnt counts the extra multiply cycles; capture on the last one.
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
            else           rsp_result <= alu_result;
         end
      end
   end

endmodule
